// File: rtl/frame_writer.sv
// frame_writer
//   Last stage of the renderer. It takes the pixel AXI-stream, packs each
//   colour to RGB444 and writes it into the back half of a double-buffered
//   framebuffer. When a frame is complete it stops accepting beats until the
//   VGA side grants a bank swap.
//
// Ports
//   aclk, aresetn         pixel clock, asynchronous active-low reset
//   pixel_axis_tdata      {R[7:0],G[7:0],B[7:0]} of the current beat
//   pixel_axis_tvalid     beat valid
//   pixel_axis_tready     registered ready; a beat is taken on tvalid&&tready
//   hcount_in, vcount_in  screen coordinates of the current beat
//   wr_addr, wr_data      RAM port-A address and {R[7:4],G[7:4],B[7:4]}
//   wr_en                 RAM port-A write enable (one cycle after acceptance)
//   display_bank          bank the VGA side scans out
//   frame_done            one-cycle pulse with the write that completes a frame
//   swap_req              VGA side ready to swap (vertical blank)
//   oob_count             saturating count of accepted out-of-window beats
module frame_writer #(
   parameter int START_X    = 390,
   parameter int START_Y    = 390,
   parameter int END_X      = 634,
   parameter int END_Y      = 765,
   parameter int ADDR_WIDTH = 18
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [23:0]           pixel_axis_tdata,
   input  logic                  pixel_axis_tvalid,
   output logic                  pixel_axis_tready,
   input  logic [10:0]           hcount_in,
   input  logic [9:0]            vcount_in,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [11:0]           wr_data,
   output logic                  wr_en,
   output logic                  display_bank,
   output logic                  frame_done,
   input  logic                  swap_req,
   output logic [15:0]           oob_count
);

   localparam int WIDTH        = END_X - START_X;
   localparam int HEIGHT       = END_Y - START_Y;
   localparam int FRAME_PIXELS = WIDTH * HEIGHT;
   localparam int CNT_W        = $clog2(FRAME_PIXELS + 1);

   localparam logic [0:0] FILL      = 1'b0;
   localparam logic [0:0] WAIT_SWAP = 1'b1;

   localparam logic [CNT_W-1:0]      FRAME_PIXELS_C = CNT_W'(FRAME_PIXELS);
   localparam logic [ADDR_WIDTH-1:0] BANK_BASE      = ADDR_WIDTH'(FRAME_PIXELS);
   localparam logic [ADDR_WIDTH-1:0] START_X_A      = ADDR_WIDTH'(START_X);
   localparam logic [ADDR_WIDTH-1:0] START_Y_A      = ADDR_WIDTH'(START_Y);
   localparam logic [ADDR_WIDTH-1:0] WIDTH_A        = ADDR_WIDTH'(WIDTH);
   localparam logic [10:0]           START_X_H      = 11'(START_X);
   localparam logic [10:0]           END_X_H        = 11'(END_X);
   localparam logic [9:0]            START_Y_V      = 10'(START_Y);
   localparam logic [9:0]            END_Y_V        = 10'(END_Y);

   logic [0:0]            state_r;
   logic [0:0]            next_state_s;
   logic                  back_bank_r;
   logic [CNT_W-1:0]      pixel_count_r;
   logic [CNT_W-1:0]      next_count_s;
   logic                  accept_s;
   logic                  in_win_s;
   logic                  write_s;
   logic                  complete_s;
   logic                  swap_s;
   logic                  oob_s;
   logic [ADDR_WIDTH-1:0] x_off_s;
   logic [ADDR_WIDTH-1:0] y_off_s;
   logic [ADDR_WIDTH-1:0] addr_s;
   logic                  unused_tdata_s;

   // Low colour bits are dropped by the RGB444 packing.
   assign unused_tdata_s = ^{pixel_axis_tdata[19:16], pixel_axis_tdata[11:8],
                             pixel_axis_tdata[3:0]};

   // Beat qualification, window test and frame-completion detect.
   always_comb begin
      accept_s     = pixel_axis_tvalid && pixel_axis_tready;
      in_win_s     = (hcount_in >= START_X_H) && (hcount_in < END_X_H) &&
                     (vcount_in >= START_Y_V) && (vcount_in < END_Y_V);
      write_s      = accept_s && in_win_s && (state_r == FILL);
      oob_s        = accept_s && !in_win_s;
      next_count_s = pixel_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      complete_s   = write_s && (next_count_s == FRAME_PIXELS_C);
      swap_s       = (state_r == WAIT_SWAP) && swap_req;
   end

   // Linear address; modular arithmetic at ADDR_WIDTH gives the same result
   // as computing at full width and truncating.
   always_comb begin
      x_off_s = ADDR_WIDTH'(hcount_in) - START_X_A;
      y_off_s = ADDR_WIDTH'(vcount_in) - START_Y_A;
      if (back_bank_r) begin
         addr_s = BANK_BASE + x_off_s + (y_off_s * WIDTH_A);
      end else begin
         addr_s = x_off_s + (y_off_s * WIDTH_A);
      end
   end

   // Next-state logic: a completed frame parks until the VGA side swaps.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         FILL: begin
            if (complete_s) begin
               next_state_s = WAIT_SWAP;
            end else begin
               next_state_s = FILL;
            end
         end
         WAIT_SWAP: begin
            if (swap_req) begin
               next_state_s = FILL;
            end else begin
               next_state_s = WAIT_SWAP;
            end
         end
         default: next_state_s = FILL;
      endcase
   end

   // Control state: FSM, bank pointers, pixel counter and registered ready.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_r           <= FILL;
         back_bank_r       <= 1'b1;
         display_bank      <= 1'b0;
         pixel_count_r     <= {CNT_W{1'b0}};
         pixel_axis_tready <= 1'b0;
         frame_done        <= 1'b0;
      end else begin
         state_r           <= next_state_s;
         pixel_axis_tready <= (next_state_s == FILL);
         frame_done        <= complete_s;
         if (swap_s) begin
            display_bank  <= back_bank_r;
            back_bank_r   <= ~back_bank_r;
            pixel_count_r <= {CNT_W{1'b0}};
         end else if (write_s) begin
            pixel_count_r <= next_count_s;
         end
      end
   end

   // Write port: one-cycle latency, address/data hold between writes.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_en   <= 1'b0;
         wr_addr <= {ADDR_WIDTH{1'b0}};
         wr_data <= 12'h000;
      end else begin
         wr_en <= write_s;
         if (write_s) begin
            wr_addr <= addr_s;
            wr_data <= {pixel_axis_tdata[23:20], pixel_axis_tdata[15:12],
                        pixel_axis_tdata[7:4]};
         end
      end
   end

   // Out-of-window counter, saturating at all-ones.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         oob_count <= 16'h0000;
      end else if (oob_s && (oob_count != 16'hFFFF)) begin
         oob_count <= oob_count + 16'h0001;
      end
   end

endmodule

// File: tb/tb_frame_writer.sv
// Self-checking bench for frame_writer. Two instances share clock, reset,
// coordinates, data and swap_req: dut 0 uses the full-size window, dut 1 a
// small 8x4 window so whole frames fit in a short run. Each has its own tvalid.
module tb_frame_writer;
   localparam int AW = 18;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [23:0] tdata;
   logic [10:0] hc;
   logic [9:0]  vc;
   logic        swap;
   logic        tvalid [2];
   logic        tready [2];
   logic [AW-1:0] waddr [2];
   logic [11:0] wdata [2];
   logic        wen [2];
   logic        dbank [2];
   logic        fdone [2];
   logic [15:0] oob [2];

   int checks = 0;
   int errors = 0;

   // window geometry per instance
   int sx [2] = '{390, 390};
   int sy [2] = '{390, 390};
   int ex [2] = '{634, 398};
   int ey [2] = '{765, 394};

   // reference model state
   bit  m_fill [2];
   bit  m_rdy [2];
   bit  m_back [2];
   bit  m_disp [2];
   bit  m_wen [2];
   bit  m_done [2];
   int  m_cnt [2];
   int  m_oob [2];
   logic [AW-1:0] m_addr [2];
   logic [11:0]   m_data [2];

   always #5 aclk = ~aclk;

   frame_writer dut0 (
      .aclk(aclk), .aresetn(aresetn),
      .pixel_axis_tdata(tdata), .pixel_axis_tvalid(tvalid[0]),
      .pixel_axis_tready(tready[0]), .hcount_in(hc), .vcount_in(vc),
      .wr_addr(waddr[0]), .wr_data(wdata[0]), .wr_en(wen[0]),
      .display_bank(dbank[0]), .frame_done(fdone[0]), .swap_req(swap),
      .oob_count(oob[0])
   );

   frame_writer #(.START_X(390), .START_Y(390), .END_X(398), .END_Y(394),
                  .ADDR_WIDTH(AW)) dut1 (
      .aclk(aclk), .aresetn(aresetn),
      .pixel_axis_tdata(tdata), .pixel_axis_tvalid(tvalid[1]),
      .pixel_axis_tready(tready[1]), .hcount_in(hc), .vcount_in(vc),
      .wr_addr(waddr[1]), .wr_data(wdata[1]), .wr_en(wen[1]),
      .display_bank(dbank[1]), .frame_done(fdone[1]), .swap_req(swap),
      .oob_count(oob[1])
   );

   function automatic int fp(int i);
      return (ex[i] - sx[i]) * (ey[i] - sy[i]);
   endfunction

   task automatic chk(string tag, int i, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, i, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_fill[i] = 1'b1; m_rdy[i] = 1'b0; m_back[i] = 1'b1; m_disp[i] = 1'b0;
         m_wen[i] = 1'b0; m_done[i] = 1'b0; m_cnt[i] = 0; m_oob[i] = 0;
         m_addr[i] = '0; m_data[i] = 12'h000;
      end
   endtask

   // Apply one clock edge of the rules to instance i using current inputs.
   task automatic model_edge(int i);
      bit acc, win, was_fill;
      int hi, vi;
      longint a;
      hi = hc;
      vi = vc;
      was_fill = m_fill[i];
      acc = tvalid[i] && m_rdy[i];
      win = (hi >= sx[i]) && (hi < ex[i]) && (vi >= sy[i]) && (vi < ey[i]);
      m_wen[i] = 1'b0;
      m_done[i] = 1'b0;
      if (acc && win) begin
         m_wen[i] = 1'b1;
         a = longint'(m_back[i]) * fp(i) + (hi - sx[i]) + (vi - sy[i]) * (ex[i] - sx[i]);
         m_addr[i] = a[AW-1:0];
         m_data[i] = {tdata[23:20], tdata[15:12], tdata[7:4]};
         m_cnt[i]++;
         if (m_cnt[i] == fp(i)) begin
            m_done[i] = 1'b1;
            m_fill[i] = 1'b0;
         end
      end else if (acc) begin
         if (m_oob[i] < 65535) m_oob[i]++;
      end
      if (!was_fill && swap) begin
         m_disp[i] = m_back[i];
         m_back[i] = !m_back[i];
         m_cnt[i] = 0;
         m_fill[i] = 1'b1;
      end
      m_rdy[i] = m_fill[i];
   endtask

   task automatic check_all();
      for (int i = 0; i < 2; i++) begin
         chk("tready", i, tready[i], m_rdy[i]);
         chk("wr_en", i, wen[i], m_wen[i]);
         chk("frame_done", i, fdone[i], m_done[i]);
         chk("display_bank", i, dbank[i], m_disp[i]);
         chk("oob_count", i, oob[i], m_oob[i]);
         chk("wr_addr", i, waddr[i], m_addr[i]);
         chk("wr_data", i, wdata[i], m_data[i]);
      end
   endtask

   task automatic step();
      model_edge(0);
      model_edge(1);
      @(posedge aclk);
      #1;
      check_all();
   endtask

   task automatic beat(int i, int h, int v, logic [23:0] d);
      hc = 11'(h); vc = 10'(v); tdata = d; tvalid[i] = 1'b1;
      step();
      tvalid[i] = 1'b0;
   endtask

   task automatic rand_in_window(int i);
      hc = 11'(sx[i] + $urandom_range(0, ex[i] - sx[i] - 1));
      vc = 10'(sy[i] + $urandom_range(0, ey[i] - sy[i] - 1));
      tdata = 24'($urandom);
   endtask

   initial begin
      int n_wr, wr_at_done, pulses, toggles, budget;
      bit prev;
      aresetn = 1'b0; tvalid[0] = 1'b0; tvalid[1] = 1'b0;
      tdata = 24'h000000; hc = 11'd0; vc = 10'd0; swap = 1'b0;
      model_reset();
      #12;
      check_all();
      @(negedge aclk);
      aresetn = 1'b1;
      step();

      // first in-window beat, then far corner of the window
      beat(0, 390, 390, 24'hF0A05F);
      chk("first_addr", 0, waddr[0], 32'd91500);
      chk("first_data", 0, wdata[0], 32'h0FA5);
      beat(0, 633, 764, 24'h123456);
      chk("corner_addr", 0, waddr[0], 32'd182999);

      // out-of-window beats on each bound
      beat(0, 389, 400, 24'hABCDEF);
      beat(0, 634, 400, 24'hABCDEF);
      beat(0, 400, 765, 24'hABCDEF);
      chk("oob_three", 0, oob[0], 32'd3);

      // drive oob_count into saturation and one past it
      hc = 11'd0; vc = 10'd0; tvalid[0] = 1'b1;
      for (int k = 0; k < 65532; k++) step();
      chk("oob_sat", 0, oob[0], 32'hFFFF);
      step();
      chk("oob_hold", 0, oob[0], 32'hFFFF);
      tvalid[0] = 1'b0;

      // partial frames on both instances, then reset with a write pending
      for (int k = 0; k < 20; k++) begin
         rand_in_window(1); tvalid[1] = 1'b1; step();
      end
      tvalid[1] = 1'b0;
      for (int k = 0; k < 500; k++) begin
         rand_in_window(0); tvalid[0] = 1'b1; step();
      end
      chk("pending_wr_en", 0, wen[0], 32'd1);
      #1 aresetn = 1'b0;
      #1;
      model_reset();
      chk("rst_wr_en", 0, wen[0], 32'd0);
      chk("rst_tready", 0, tready[0], 32'd0);
      check_all();
      tvalid[0] = 1'b0;
      @(negedge aclk);
      aresetn = 1'b1;
      step();

      // full small frame after reset, with random gaps
      n_wr = 0; wr_at_done = 0; pulses = 0; budget = 0;
      while (m_fill[1] && budget < 1000) begin
         rand_in_window(1);
         tvalid[1] = ($urandom_range(0, 3) != 0);
         step();
         if (wen[1]) n_wr++;
         if (fdone[1]) begin pulses++; wr_at_done = n_wr; end
         budget++;
      end
      chk("frame_in_budget", 1, 32'(m_fill[1]), 32'd0);
      chk("done_pulses", 1, 32'(pulses), 32'd1);
      chk("done_at_write", 1, 32'(wr_at_done), 32'd32);

      // parked: tvalid high for 100 cycles, nothing may be written
      n_wr = 0;
      tvalid[1] = 1'b1;
      for (int k = 0; k < 100; k++) begin
         rand_in_window(1); step();
         if (wen[1] || tready[1]) n_wr++;
      end
      chk("parked_quiet", 1, 32'(n_wr), 32'd0);
      tvalid[1] = 1'b0;
      swap = 1'b1;
      step();
      swap = 1'b0;
      chk("swap_bank", 1, dbank[1], 32'd1);
      chk("swap_ready", 1, tready[1], 32'd1);
      beat(1, 393, 391, 24'h808080);
      chk("bank0_addr", 1, waddr[1], 32'd11);

      // swap_req held high through fill and completion: one toggle only
      swap = 1'b1; toggles = 0; prev = dbank[1]; budget = 0;
      tvalid[1] = 1'b1;
      while (budget < 200 && (m_fill[1] || budget < 40)) begin
         rand_in_window(1); step();
         if (dbank[1] != prev) toggles++;
         prev = dbank[1];
         budget++;
      end
      chk("one_toggle", 1, 32'(toggles), 32'd1);
      chk("toggle_bank", 1, dbank[1], 32'd0);
      swap = 1'b0; tvalid[1] = 1'b0;

      // random mix around the small window on both instances
      for (int k = 0; k < 2000; k++) begin
         hc = 11'(386 + $urandom_range(0, 15));
         vc = 10'(386 + $urandom_range(0, 11));
         tdata = 24'($urandom);
         tvalid[0] = ($urandom_range(0, 3) == 0);
         tvalid[1] = ($urandom_range(0, 3) != 0);
         swap = ($urandom_range(0, 7) == 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
